// File: rtl/mem_dump_reader.sv
// Walks a range of data-memory words through the debug read port and streams
// each word out little-endian, one byte per valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for i_start; latches start address and word count
// ISSUE | one-cycle read strobe with the current address
// WAIT  | counting down the memory read latency, then capturing the word
// SEND  | presenting bytes 0..3 of the captured word to the transmitter
// DONE  | one-cycle completion pulse
module mem_dump_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 64,
  parameter int ADDR_WIDTH   = $clog2(MEM_SIZE),
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  output logic [ADDR_WIDTH-1:0] o_debug_addr,
  output logic                  o_mem_read_en,
  input  logic [DATA_WIDTH-1:0] i_debug_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int LAT_W = (READ_LATENCY > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [1:0]            idx_q, idx_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_d       = words_q;
    idx_d         = idx_q;
    lat_d         = lat_q;
    data_d        = data_q;
    o_mem_read_en = 1'b0;
    o_tx_valid    = 1'b0;
    o_tx_data     = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d  = i_start_addr;
          words_d = i_num_words;
          state_d = (i_num_words == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_mem_read_en = 1'b1;
        lat_d         = LAT_W'(READ_LATENCY - 1);
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          data_d  = i_debug_data;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = data_q[{idx_q, 3'b000} +: 8];
        if (i_tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Address wraps naturally at the memory size.
            if (words_q == (ADDR_WIDTH+1)'(1)) begin
              state_d = ST_DONE;
            end else begin
              words_d = words_q - (ADDR_WIDTH+1)'(1);
              addr_d  = addr_q + ADDR_WIDTH'(4);
              state_d = ST_ISSUE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_debug_addr = addr_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: two instances (read latency 1 and 3) share the
// stimulus; each has its own memory model and queue-based scoreboard.
module tb_mem_dump_reader;

  localparam int MS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [5:0] start_addr;
  logic [6:0] num_words;
  logic       tx_ready;

  logic [5:0]  dbg_addr [2];
  logic        rd_en    [2];
  logic [31:0] dbg_data [2];
  logic [7:0]  tx_data  [2];
  logic        tx_valid [2];
  logic        busy     [2];
  logic        done     [2];

  logic [7:0] mem [MS];
  logic [7:0] exp_b [2][$];
  logic [5:0] exp_a [2][$];
  int         exp_d [2];
  int         done_cyc [2];
  int         lat_of [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s_cyc = 0;
  bit rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  function automatic logic [31:0] rd_word(input logic [5:0] a);
    logic [5:0] a1, a2, a3;
    a1 = a + 6'd1;
    a2 = a + 6'd2;
    a3 = a + 6'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic        pv [4];
    logic [5:0]  pa [4];
    logic [31:0] garbage;
    logic        pvld, prdy;
    logic [7:0]  pdat;

    mem_dump_reader #(.READ_LATENCY(LAT)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (start),
      .i_start_addr  (start_addr),
      .i_num_words   (num_words),
      .o_debug_addr  (dbg_addr[g]),
      .o_mem_read_en (rd_en[g]),
      .i_debug_data  (dbg_data[g]),
      .o_tx_data     (tx_data[g]),
      .o_tx_valid    (tx_valid[g]),
      .i_tx_ready    (tx_ready),
      .o_busy        (busy[g]),
      .o_done        (done[g])
    );

    initial begin
      lat_of[g] = LAT;
      for (int i = 0; i < 4; i++) begin
        pv[i] = 1'b0;
        pa[i] = '0;
      end
      garbage = 32'h0;
      pvld = 1'b0;
      prdy = 1'b0;
      pdat = 8'h00;
    end

    // Memory model: the word is on the bus only LAT cycles after the strobe,
    // otherwise the bus carries fresh random junk every cycle.
    always @(posedge clk) begin
      garbage <= $urandom;
      pv[0]   <= rd_en[g];
      pa[0]   <= dbg_addr[g];
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
    assign dbg_data[g] = pv[LAT-1] ? rd_word(pa[LAT-1]) : garbage;

    always @(negedge clk) begin
      if (rst) begin
        pvld <= 1'b0;
      end else begin
        if (pvld && !prdy) begin
          check($sformatf("i%0d_hold_valid", g), int'(tx_valid[g]), 1);
          if (tx_valid[g]) check($sformatf("i%0d_hold_data", g), int'(tx_data[g]), int'(pdat));
        end
        if (tx_valid[g] && tx_ready) begin
          if (exp_b[g].size() == 0) fail_now($sformatf("i%0d_extra_byte", g));
          else check($sformatf("i%0d_byte", g), int'(tx_data[g]), int'(exp_b[g].pop_front()));
        end
        if (rd_en[g]) begin
          if (exp_a[g].size() == 0) fail_now($sformatf("i%0d_extra_read", g));
          else check($sformatf("i%0d_rd_addr", g), int'(dbg_addr[g]), int'(exp_a[g].pop_front()));
        end
        if (done[g]) begin
          if (exp_d[g] == 0) fail_now($sformatf("i%0d_extra_done", g));
          else begin
            exp_d[g]--;
            check($sformatf("i%0d_busy_in_done", g), int'(busy[g]), 1);
            done_cyc[g] = cyc;
          end
        end
        pvld <= tx_valid[g];
        prdy <= tx_ready;
        pdat <= tx_data[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1]) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) fail_now("idle_timeout");
  endtask

  task automatic wait_both_valid();
    int n = 0;
    while (!(tx_valid[0] && tx_valid[1]) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_now("valid_timeout");
  endtask

  task automatic start_dump(input logic [5:0] sa, input logic [6:0] n);
    logic [5:0] a, b;
    wait_idle();
    for (int g = 0; g < 2; g++) begin
      for (int w = 0; w < int'(n); w++) begin
        a = sa + 6'(4 * w);
        exp_a[g].push_back(a);
        for (int k = 0; k < 4; k++) begin
          b = a + 6'(k);
          exp_b[g].push_back(mem[b]);
        end
      end
      exp_d[g]++;
    end
    start      = 1'b1;
    start_addr = sa;
    num_words  = n;
    s_cyc      = cyc;
    tick();
    start      = 1'b0;
    start_addr = 6'($urandom);
    num_words  = 7'($urandom);
  endtask

  task automatic finish_check(input string name);
    wait_idle();
    tick();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_i%0d_bytes_left", name, g), exp_b[g].size(), 0);
      check($sformatf("%s_i%0d_reads_left", name, g), exp_a[g].size(), 0);
      check($sformatf("%s_i%0d_done_left", name, g), exp_d[g], 0);
    end
  endtask

  task automatic check_timing(input string name, input int n);
    for (int g = 0; g < 2; g++) begin
      int want;
      want = (n == 0) ? 1 : n * (5 + lat_of[g]) + 1;
      check($sformatf("%s_i%0d_cycles", name, g), done_cyc[g] - s_cyc, want);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    num_words  = '0;
    tx_ready   = 1'b0;
    exp_d[0]   = 0;
    exp_d[1]   = 0;
    for (int i = 0; i < MS; i++) mem[i] = 8'($urandom);
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_i%0d_valid", g), int'(tx_valid[g]), 0);
      check($sformatf("rst_i%0d_busy", g), int'(busy[g]), 0);
      check($sformatf("rst_i%0d_done", g), int'(done[g]), 0);
      check($sformatf("rst_i%0d_rd_en", g), int'(rd_en[g]), 0);
      check($sformatf("rst_i%0d_addr", g), int'(dbg_addr[g]), 0);
      check($sformatf("rst_i%0d_data", g), int'(tx_data[g]), 0);
    end
    rst = 1'b0;
    tick();

    // single word, ready always high
    mem[0] = 8'hEF; mem[1] = 8'hBE; mem[2] = 8'hAD; mem[3] = 8'hDE;
    tx_ready = 1'b1;
    start_dump(6'd0, 7'd1);
    finish_check("single");
    check_timing("single", 1);

    // three words wrapping past the top; a start mid-dump must be ignored
    start_dump(6'd56, 7'd3);
    repeat (4) tick();
    start      = 1'b1;
    start_addr = 6'd8;
    num_words  = 7'd5;
    tick();
    start = 1'b0;
    finish_check("wrap");
    check_timing("wrap", 3);

    // zero length
    start_dump(6'd5, 7'd0);
    finish_check("zero");
    check_timing("zero", 0);

    // backpressure on byte 2 of 0x11223344
    mem[20] = 8'h44; mem[21] = 8'h33; mem[22] = 8'h22; mem[23] = 8'h11;
    tx_ready = 1'b0;
    start_dump(6'd20, 7'd1);
    wait_both_valid();
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int g = 0; g < 2; g++) begin
        check($sformatf("bp_i%0d_data", g), int'(tx_data[g]), 8'h22);
        check($sformatf("bp_i%0d_valid", g), int'(tx_valid[g]), 1);
      end
      tick();
    end
    tx_ready = 1'b1;
    finish_check("bp");

    // randomized dumps with random backpressure
    rnd_rdy = 1'b1;
    for (int t = 0; t < 15; t++) begin
      wait_idle();
      for (int i = 0; i < MS; i++) mem[i] = 8'($urandom);
      start_dump(6'($urandom), 7'($urandom_range(0, 20)));
      finish_check("rand");
    end
    rnd_rdy = 1'b0;

    // reset after two bytes of the first word
    tx_ready = 1'b0;
    start_dump(6'd12, 7'd2);
    wait_both_valid();
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("mrst_i%0d_valid", g), int'(tx_valid[g]), 0);
      check($sformatf("mrst_i%0d_busy", g), int'(busy[g]), 0);
      check($sformatf("mrst_i%0d_done", g), int'(done[g]), 0);
      check($sformatf("mrst_i%0d_bytes_sent", g), exp_b[g].size(), 6);
      exp_b[g].delete();
      exp_a[g].delete();
      exp_d[g] = 0;
    end
    tick();
    tx_ready = 1'b1;
    start_dump(6'd33, 7'd2);
    finish_check("after_rst");
    check_timing("after_rst", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
